// File: rtl/fsm_input_pkg.sv
// Shared definitions for the input-conditioning blocks that feed the X-driven FSM.
// Contents:
//   state_e              - 2-bit debounce state encoding, also exported on Estado_Salida
//   SYNC_STAGES_DEF      - default synchroniser depth
//   DEBOUNCE_CYCLES_DEF  - default number of agreeing samples after the first changed one
package fsm_input_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'b00,
    CHECK_HIGH = 2'b01,
    IDLE_HIGH  = 2'b10,
    CHECK_LOW  = 2'b11
  } state_e;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/x_input_conditioner_if.sv
// Signal bundle between the raw-input source and the conditioner.
//   raw_in        - asynchronous raw switch/button level
//   X_out         - debounced, registered level (feeds the downstream FSM's X)
//   rise_pulse    - one-cycle strobe on an accepted 0->1
//   fall_pulse    - one-cycle strobe on an accepted 1->0
//   edge_count    - wrapping count of accepted transitions
//   Estado_Salida - current debounce state, for observation
// modport master: the source / observer side; modport slave: the conditioner.
interface x_input_conditioner_if;

  logic       raw_in;
  logic       X_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] edge_count;
  logic [1:0] Estado_Salida;

  modport master (
    output raw_in,
    input  X_out,
    input  rise_pulse,
    input  fall_pulse,
    input  edge_count,
    input  Estado_Salida
  );

  modport slave (
    input  raw_in,
    output X_out,
    output rise_pulse,
    output fall_pulse,
    output edge_count,
    output Estado_Salida
  );

endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit.
//   Clk   - destination clock, rising edge
//   Reset - asynchronous active-high reset, clears every stage to 0
//   d     - asynchronous input
//   q     - synchronised output (last stage)
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/x_input_conditioner.sv
// Synchronises and debounces a bouncy raw input into a clean X level.
//   Clk   - system clock, rising edge
//   Reset - asynchronous active-high reset
//   bus   - slave side of x_input_conditioner_if (raw_in in; X_out, strobes,
//           edge_count and Estado_Salida out, all registered)
// A new level is accepted after DEBOUNCE_CYCLES+1 consecutive synchronised samples
// that differ from X_out; shorter runs return to the idle state with no output change.
module x_input_conditioner
  import fsm_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  x_input_conditioner_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_x;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [7:0]       edges_q, edges_d;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (bus.raw_in),
    .q     (sync_x)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    edges_d = edges_q;
    case (state_q)
      IDLE_LOW: begin
        if (sync_x) begin
          state_d = CHECK_HIGH;
          cnt_d   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!sync_x) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          x_d     = 1'b1;
          rise_d  = 1'b1;
          edges_d = edges_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync_x) begin
          state_d = CHECK_LOW;
          cnt_d   = '0;
        end
      end
      CHECK_LOW: begin
        if (sync_x) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          x_d     = 1'b0;
          fall_d  = 1'b1;
          edges_d = edges_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      edges_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      edges_q <= edges_d;
    end
  end

  assign bus.X_out         = x_q;
  assign bus.rise_pulse    = rise_q;
  assign bus.fall_pulse    = fall_q;
  assign bus.edge_count    = edges_q;
  assign bus.Estado_Salida = state_q;

endmodule

// File: tb/tb_x_input_conditioner.sv
module tb_x_input_conditioner;
  import fsm_input_pkg::*;

  localparam int SS = 2;
  localparam int DC = 4;

  logic Clk;
  logic Reset;

  x_input_conditioner_if bus ();

  x_input_conditioner #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: raw samples delayed by SS edges, then a run-length rule.
  bit q_sync[$];
  bit m_x;
  int m_run;
  bit m_rise, m_fall;
  int m_cnt;

  task automatic model_reset();
    q_sync.delete();
    for (int i = 0; i < SS; i++) q_sync.push_back(1'b0);
    m_x = 0; m_run = 0; m_rise = 0; m_fall = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit r);
    bit sx;
    sx = q_sync.pop_front();
    q_sync.push_back(r);
    m_rise = 0;
    m_fall = 0;
    if (sx != m_x) begin
      m_run++;
      if (m_run == DC + 1) begin
        m_x   = sx;
        m_run = 0;
        m_cnt = (m_cnt + 1) % 256;
        if (sx) m_rise = 1; else m_fall = 1;
      end
    end else begin
      m_run = 0;
    end
  endtask

  function automatic logic [12:0] exp_vec();
    logic [7:0] c;
    c = 8'(m_cnt);
    return {m_x, m_rise, m_fall, c, m_x, (m_run != 0)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {bus.X_out, bus.rise_pulse, bus.fall_pulse, bus.edge_count, bus.Estado_Salida};
  endfunction

  task automatic step(input bit r);
    @(negedge Clk);
    bus.raw_in = r;
    @(posedge Clk);
    #1;
    model_edge(r);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    bus.raw_in = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    int rises, rise_idx;
    Reset = 1'b1;
    bus.raw_in = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge Clk);
      #1;
      n_cmp++;
      if (dut_vec() !== 13'd0) begin
        n_bad++; $display("FAIL reset_hold: got %b want %b", dut_vec(), 13'd0);
      end
    end
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL reset_low cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    rises = 0; rise_idx = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL reset_step cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (bus.rise_pulse) rises++;
      if (bus.X_out && rise_idx < 0) rise_idx = i;
    end
    n_cmp++;
    if (rise_idx != 6) begin
      n_bad++; $display("FAIL step_latency: got %0d want 6", rise_idx);
    end
    n_cmp++;
    if (rises != 1) begin
      n_bad++; $display("FAIL step_rise_count: got %0d want 1", rises);
    end
    n_cmp++;
    if (bus.edge_count !== 8'd1 || bus.Estado_Salida !== 2'b10) begin
      n_bad++;
      $display("FAIL step_final: got cnt %0d st %b want 1 10", bus.edge_count, bus.Estado_Salida);
    end
  endtask

  task automatic test_glitch();
    bit saw01;
    int strobes;
    do_reset();
    saw01 = 0; strobes = 0;
    for (int w = 1; w <= 4; w++) begin
      for (int i = 0; i < w + 8; i++) begin
        step(i < w);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_bad++; $display("FAIL glitch w%0d cyc %0d: got %b want %b", w, i, dut_vec(), exp_vec());
        end
        if (bus.Estado_Salida === 2'b01) saw01 = 1;
        if (bus.rise_pulse || bus.fall_pulse) strobes++;
      end
    end
    n_cmp++;
    if (!saw01 || strobes != 0 || bus.X_out !== 1'b0 || bus.edge_count !== 8'd0
        || bus.Estado_Salida !== 2'b00) begin
      n_bad++;
      $display("FAIL glitch_final: saw01 %0d strobes %0d x %b cnt %0d st %b want 1 0 0 0 00",
               saw01, strobes, bus.X_out, bus.edge_count, bus.Estado_Salida);
    end
  endtask

  task automatic test_boundary();
    int rises, falls;
    do_reset();
    rises = 0; falls = 0;
    for (int i = 0; i < 22; i++) begin
      step(i >= 3 && i < 8);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL boundary cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (bus.rise_pulse) rises++;
      if (bus.fall_pulse) falls++;
    end
    n_cmp++;
    if (rises != 1 || falls != 1 || bus.edge_count !== 8'd2 || bus.X_out !== 1'b0) begin
      n_bad++;
      $display("FAIL boundary_final: rises %0d falls %0d cnt %0d x %b want 1 1 2 0",
               rises, falls, bus.edge_count, bus.X_out);
    end
  endtask

  task automatic test_bounce();
    bit pat [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int falls, fall_idx;
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1);
    n_cmp++;
    if (bus.Estado_Salida !== 2'b10 || bus.edge_count !== 8'd1) begin
      n_bad++;
      $display("FAIL bounce_setup: st %b cnt %0d want 10 1", bus.Estado_Salida, bus.edge_count);
    end
    falls = 0; fall_idx = -1;
    for (int i = 0; i < 18; i++) begin
      step(i < 6 ? pat[i] : 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL bounce cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (bus.fall_pulse) begin
        falls++;
        fall_idx = i;
      end
    end
    n_cmp++;
    if (falls != 1 || fall_idx != 11 || bus.edge_count !== 8'd2) begin
      n_bad++;
      $display("FAIL bounce_final: falls %0d at %0d cnt %0d want 1 at 11 cnt 2",
               falls, fall_idx, bus.edge_count);
    end
  endtask

  task automatic test_reset_mid();
    int rises;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(i >= 4);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL mid_setup cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (bus.Estado_Salida !== 2'b01 || m_run != 3) begin
      n_bad++; $display("FAIL mid_state: st %b run %0d want 01 3", bus.Estado_Salida, m_run);
    end
    #3;
    Reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec() !== 13'd0) begin
      n_bad++; $display("FAIL mid_async_reset: got %b want %b", dut_vec(), 13'd0);
    end
    @(negedge Clk);
    bus.raw_in = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    rises = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL mid_after cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (bus.rise_pulse) rises++;
    end
    n_cmp++;
    if (rises != 0) begin
      n_bad++; $display("FAIL mid_no_rise: got %0d want 0", rises);
    end
  endtask

  task automatic test_wrap();
    bit lvl;
    int pulses, last_kind;
    do_reset();
    lvl = 0; pulses = 0; last_kind = 0;
    for (int t = 0; t < 256; t++) begin
      lvl = ~lvl;
      for (int i = 0; i < 10; i++) begin
        step(lvl);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_bad++;
          $display("FAIL wrap t%0d cyc %0d: got %b want %b", t, i, dut_vec(), exp_vec());
        end
        if (bus.rise_pulse || bus.fall_pulse) begin
          pulses++;
          n_cmp++;
          if ((bus.rise_pulse && last_kind == 1) || (bus.fall_pulse && last_kind != 1)) begin
            n_bad++;
            $display("FAIL wrap_alternate t%0d: rise %b fall %b last %0d",
                     t, bus.rise_pulse, bus.fall_pulse, last_kind);
          end
          last_kind = bus.rise_pulse ? 1 : 2;
        end
      end
    end
    n_cmp++;
    if (pulses != 256 || bus.edge_count !== 8'd0) begin
      n_bad++;
      $display("FAIL wrap_final: pulses %0d cnt %0d want 256 0", pulses, bus.edge_count);
    end
  endtask

  task automatic test_random();
    bit lvl;
    int len;
    do_reset();
    for (int r = 0; r < 80; r++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        step(lvl);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_bad++;
          $display("FAIL random run %0d cyc %0d: got %b want %b", r, i, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus.raw_in = 1'b0;
    test_reset();
    test_glitch();
    test_boundary();
    test_bounce();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/x_input_conditioner.md
Name: x_input_conditioner

Overview:
- Upstream stage of the X-driven state machine.
- Takes an asynchronous, bouncy raw input (switch or pushbutton), synchronises it to Clk and debounces it with a 4-state FSM.
- Drives a clean, registered X plus single-cycle edge strobes and a debug state output for the testbench.
- Its X_out connects directly to the downstream FSM's X input.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range >= 2.
- DEBOUNCE_CYCLES, 4, consecutive agreeing samples required after the first changed sample; legal range >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, debounce counter width; derived, never overridden.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset; the block leaves reset synchronously on Clk.
- raw_in  input  1  asynchronous raw input.
- X_out  output  1  debounced level; feeds the downstream FSM's X.
- rise_pulse  output  1  one-cycle strobe when X_out goes 0->1.
- fall_pulse  output  1  one-cycle strobe when X_out goes 1->0.
- edge_count  output  8  count of accepted transitions, both directions.
- Estado_Salida  output  2  current debounce state, for TB observation.

Behaviour:
- Reset (async, any time, including mid-debounce):
  - sync chain = 0, state = IDLE_LOW, counter = 0.
  - X_out = 0, rise_pulse = 0, fall_pulse = 0, edge_count = 0.
- Synchroniser: SYNC_STAGES flops in series; the FSM uses only the last stage (sync_x). raw_in is never used combinationally.
- State encoding:
  - IDLE_LOW = 2'b00
  - CHECK_HIGH = 2'b01
  - IDLE_HIGH = 2'b10
  - CHECK_LOW = 2'b11
- Estado_Salida = state.
- IDLE_LOW: if sync_x == 1, go to CHECK_HIGH with cnt = 0; otherwise stay.
- CHECK_HIGH:
  - sync_x == 0: return to IDLE_LOW, cnt = 0, no strobe.
  - sync_x == 1 and cnt == DEBOUNCE_CYCLES-1: go to IDLE_HIGH; on the same edge X_out <= 1, rise_pulse <= 1, edge_count++.
  - sync_x == 1 otherwise: cnt++.
- IDLE_HIGH / CHECK_LOW: mirror image of IDLE_LOW / CHECK_HIGH with polarity inverted. Acceptance sets X_out <= 0, fall_pulse <= 1, edge_count++.
- Strobes:
  - Registered; high for exactly one cycle, cleared on the next edge.
  - rise_pulse and fall_pulse are never high together.
- Acceptance rule: a level is accepted after exactly DEBOUNCE_CYCLES+1 consecutive equal sync_x samples differing from X_out. Runs of <= DEBOUNCE_CYCLES samples are rejected with no output change.
- Latency: raw_in stable from before edge 0 gives X_out changed after edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 6, i.e. 7 edges, at defaults).
- edge_count: 8-bit, wraps 255->0, no saturation.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1. There is no unreachable-state lockup; default branch -> IDLE_LOW.
- X_out is always a flop output, glitch-free. Sample timing is not affected by X_out feeding the downstream FSM.
- Simultaneous events:
  - Reset has priority over everything.
  - A sync_x reversal on the exact acceptance edge is not possible, because acceptance requires sync_x to still be at the new level on that edge.

Decomposition:
- Shared package fsm_input_pkg:
  - State enum/constants IDLE_LOW..CHECK_LOW (2 bits).
  - Default SYNC_STAGES and DEBOUNCE_CYCLES.
- One sub-module, sync_chain:
  - Parameterised SYNC_STAGES flop chain with async active-high reset to 0.
  - Reused by later input blocks.
- FSM, counter and strobes live in x_input_conditioner.

Test Plan:
- Reset and step:
  - Stimulus: Reset high 3 cycles, then release; raw_in 0 for 10 cycles, then 1 and held.
  - Required: X_out=0, Estado_Salida=00 during the 0 phase. X_out=1 after 7 edges from the change; rise_pulse high exactly 1 cycle; edge_count=1; Estado_Salida ends at 10.
- Glitch rejection:
  - Stimulus: from IDLE_LOW, raw_in pulses high for 1, 2, 3 and 4 cycles, separated by 8 low cycles.
  - Required: X_out stays 0, no strobes, edge_count=0; Estado_Salida visits 01 and returns to 00.
- Acceptance boundary:
  - Stimulus: raw_in high for exactly 5 cycles (DEBOUNCE_CYCLES+1), then low.
  - Required: X_out rises with rise_pulse. Then it falls after a further 5 stable low samples with fall_pulse; edge_count=2.
- Bounce on release:
  - Stimulus: from IDLE_HIGH, raw_in pattern 0,1,0,0,1,0 (each 1 cycle), then 0 held.
  - Required: exactly one fall_pulse, only after the final stable run; edge_count incremented by 1.
- Reset mid-operation:
  - Stimulus: assert Reset asynchronously (between clock edges) while in CHECK_HIGH with cnt=2.
  - Required: state 00, X_out=0, edge_count=0 immediately, before the next Clk edge; no rise_pulse after release while raw_in stays 0.
- Counter wrap:
  - Stimulus: 256 clean toggles of raw_in, each level held 10 cycles.
  - Required: edge_count returns to 0 after the 256th accepted edge; strobes alternate rise/fall.
